// File: rtl/riscv_pkg.sv
// Shared RV64 decode constants and the instruction-fetch state encoding.
// Pure definitions; no latency or flow control of its own.
package riscv_pkg;

   localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] INSTR_NOP  = 32'h00000013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: PC owner, one outstanding imem request, holds the instruction for decode.
// Best case gnt->if_valid is 2 cycles; decode stalls with if_ready=0 and fetch waits in HOLD.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [31:0]      if_instr,
   output logic [6:0]       if_opcode,
   output logic [XLEN-1:0]  if_pc,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc
);

   fetch_state_t     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             kill_q, kill_d;
   logic [31:0]      if_instr_q, if_instr_d;
   logic [XLEN-1:0]  if_pc_q, if_pc_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;

      case (state_q)
         REQ: begin
            if (imem_gnt) begin
               state_d = WAIT;
               kill_d  = redirect_valid;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               // A response belonging to a redirected-away path is dropped.
               if (kill_q || redirect_valid) begin
                  state_d = REQ;
                  kill_d  = 1'b0;
               end else begin
                  state_d    = HOLD;
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc_q;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               state_d = REQ;
            end else if (if_ready) begin
               state_d = REQ;
               pc_d    = pc_q + XLEN'(4);
            end
         end
         default: state_d = REQ;
      endcase

      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= REQ;
         pc_q       <= RESET_PC;
         kill_q     <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   // Gated by rst so no request escapes while memory is being reset alongside us.
   assign imem_req  = (state_q == REQ) && !rst;
   assign imem_addr = pc_q;
   assign if_valid  = (state_q == HOLD);
   assign if_instr  = if_instr_q;
   assign if_opcode = if_instr_q[6:0];
   assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: per-cycle input/expected-output table plus a PC-wrap sequence.
module tb_instr_fetch;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [6:0]  if_opcode;
   logic [63:0] if_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int n_checks = 0;
   int n_err    = 0;

   instr_fetch #(.XLEN(64), .RESET_PC(64'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_opcode      (if_opcode),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, gnt, rvalid;
      logic [31:0] rdata;
      logic        ready, rv;
      logic [63:0] rpc;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [63:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic g, logic rv_in, logic [31:0] d, logic rdy,
                               logic rdv, logic [63:0] rpc, logic e_req, logic [63:0] e_addr,
                               logic e_vld, logic [31:0] e_instr, logic [63:0] e_pc);
      vec_t v;
      v.rst = r; v.gnt = g; v.rvalid = rv_in; v.rdata = d; v.ready = rdy;
      v.rv = rdv; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
      v.e_vld = e_vld; v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; imem_gnt = v.gnt; imem_rvalid = v.rvalid; imem_rdata = v.rdata;
      if_ready = v.ready; redirect_valid = v.rv; redirect_pc = v.rpc;
   endtask

   initial begin
      vec_t v;
      int   n;
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

      //            rst gnt rvl rdata         rdy rdv rpc      | req addr     vld instr         if_pc
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 64'h0,     0, 64'h0,   0, 32'h0,        64'h0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 64'h0,     1, 64'h0,   0, 32'h0,        64'h0));
      vecs.push_back(mk(0, 0, 1, 32'h00000033, 0, 0, 64'h0,     0, 64'h0,   0, 32'h0,        64'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 64'h0,     0, 64'h0,   1, 32'h00000033, 64'h0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 64'h0,     1, 64'h4,   0, 32'h00000033, 64'h0));
      vecs.push_back(mk(0, 0, 1, 32'h00003003, 0, 0, 64'h0,     0, 64'h4,   0, 32'h00000033, 64'h0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 64'h0,     0, 64'h4,   1, 32'h00003003, 64'h4));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 64'h0,     0, 64'h4,   1, 32'h00003003, 64'h4));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 64'h0,     1, 64'h8,   0, 32'h00003003, 64'h4));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 64'h0,     1, 64'h8,   0, 32'h00003003, 64'h4));
      // redirect while waiting; stale branch word must not surface
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 64'h100,   0, 64'h8,   0, 32'h00003003, 64'h4));
      vecs.push_back(mk(0, 0, 1, 32'h00000063, 0, 0, 64'h0,     0, 64'h100, 0, 32'h00003003, 64'h4));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 64'h0,     1, 64'h100, 0, 32'h00003003, 64'h4));
      vecs.push_back(mk(0, 0, 1, 32'h00000013, 0, 0, 64'h0,     0, 64'h100, 0, 32'h00003003, 64'h4));
      // redirect in HOLD with concurrent if_ready
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 64'h203,   0, 64'h100, 1, 32'h00000013, 64'h100));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 64'h0,     1, 64'h200, 0, 32'h00000013, 64'h100));
      // redirect on the granting cycle
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 64'h300,   1, 64'h200, 0, 32'h00000013, 64'h100));
      vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 64'h0,     0, 64'h300, 0, 32'h00000013, 64'h100));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 64'h0,     1, 64'h300, 0, 32'h00000013, 64'h100));
      // reset while waiting
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 64'h0,     0, 64'h300, 0, 32'h00000013, 64'h100));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 64'h0,     0, 64'h0,   0, 32'h0,        64'h0));
      // rvalid in REQ is ignored
      vecs.push_back(mk(0, 0, 1, 32'hBADBAD00, 0, 0, 64'h0,     1, 64'h0,   0, 32'h0,        64'h0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 64'h0,     1, 64'h0,   0, 32'h0,        64'h0));
      vecs.push_back(mk(0, 0, 1, 32'h00000023, 0, 0, 64'h0,     0, 64'h0,   0, 32'h0,        64'h0));
      // rvalid in HOLD is ignored
      vecs.push_back(mk(0, 0, 1, 32'h11111111, 0, 0, 64'h0,     0, 64'h0,   1, 32'h00000023, 64'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 64'h0,     0, 64'h0,   1, 32'h00000023, 64'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 64'h0,     1, 64'h4,   0, 32'h00000023, 64'h0));

      @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         #1;
         chk($sformatf("v%0d_req", i),    {63'h0, imem_req}, {63'h0, v.e_req});
         chk($sformatf("v%0d_addr", i),   imem_addr,         v.e_addr);
         chk($sformatf("v%0d_valid", i),  {63'h0, if_valid}, {63'h0, v.e_vld});
         chk($sformatf("v%0d_instr", i),  {32'h0, if_instr}, {32'h0, v.e_instr});
         chk($sformatf("v%0d_opcode", i), {57'h0, if_opcode}, {57'h0, v.e_instr[6:0]});
         chk($sformatf("v%0d_pc", i),     if_pc,             v.e_pc);
      end

      // PC wrap: redirect to the last word, fetch it, then +4 must wrap to 0
      @(negedge clk);
      rst = 0; imem_gnt = 0; imem_rvalid = 0; if_ready = 0;
      redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      redirect_valid = 0; imem_gnt = 1;
      #1;
      chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_req", {63'h0, imem_req}, 64'h1);
      @(negedge clk);
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00000033;
      @(negedge clk);
      imem_rvalid = 0;
      n = 0;
      while (!if_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("wrap_valid", {63'h0, if_valid}, 64'h1);
      chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_opcode", {57'h0, if_opcode}, {57'h0, OPC_RTYPE});
      if_ready = 1;
      @(negedge clk);
      if_ready = 0;
      #1;
      chk("wrap_next_addr", imem_addr, 64'h0);
      chk("wrap_next_req", {63'h0, imem_req}, 64'h1);
      chk("wrap_vld_drop", {63'h0, if_valid}, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
